// File: rtl/fetch_queue.sv
// fetch_queue: IF -> ID bundle FIFO with valid/ready handshake and one-cycle flush.
// Head data is read asynchronously from storage and forced to zero while empty.
module fetch_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inValid,
   input  logic [XLEN-1:0]          inPc,
   input  logic [XLEN-1:0]          inPcN,
   input  logic [XLEN-1:0]          inInst,
   output logic                     inReady,
   input  logic                     flush,
   output logic                     outValid,
   output logic [XLEN-1:0]          outPc,
   output logic [XLEN-1:0]          outPcN,
   output logic [XLEN-1:0]          outInst,
   input  logic                     outReady,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] pc_mem_d   [DEPTH];
   logic [XLEN-1:0] pcn_mem_q  [DEPTH];
   logic [XLEN-1:0] pcn_mem_d  [DEPTH];
   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] inst_mem_d [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic push, pop;

   // Status flags depend only on registered occupancy, so inReady never sees outReady.
   assign inReady  = (count_q != CntW'(DEPTH));
   assign outValid = (count_q != '0);
   assign count    = count_q;

   // Handshake qualifiers; a full queue refuses a push even when a pop frees a slot.
   assign push = inValid && inReady;
   assign pop  = outValid && outReady;

   // Head presentation: entry at the read pointer, zeroed while the queue is empty.
   always_comb begin
      outPc   = '0;
      outPcN  = '0;
      outInst = '0;
      if (outValid) begin
         outPc   = pc_mem_q[rd_ptr_q];
         outPcN  = pcn_mem_q[rd_ptr_q];
         outInst = inst_mem_q[rd_ptr_q];
      end
   end

   // Pointer and occupancy next state; flush voids any push or pop this cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   // Storage next state; a bundle arriving alongside flush is dropped, contents are never cleared.
   always_comb begin
      pc_mem_d   = pc_mem_q;
      pcn_mem_d  = pcn_mem_q;
      inst_mem_d = inst_mem_q;
      if (push && !flush && !rst) begin
         pc_mem_d[wr_ptr_q]   = inPc;
         pcn_mem_d[wr_ptr_q]  = inPcN;
         inst_mem_d[wr_ptr_q] = inInst;
      end
   end

   // Control registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage has no reset; stale contents are unreachable once count is zero.
   always_ff @(posedge clk) begin
      pc_mem_q   <= pc_mem_d;
      pcn_mem_q  <= pcn_mem_d;
      inst_mem_q <= inst_mem_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed vectors plus hand-written backpressure checks.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [31:0] inPc;
   logic [31:0] inPcN;
   logic [31:0] inInst;
   logic        inReady;
   logic        flush;
   logic        outValid;
   logic [31:0] outPc;
   logic [31:0] outPcN;
   logic [31:0] outInst;
   logic        outReady;
   logic [2:0]  count;

   int total;
   int bad;

   fetch_queue #(
      .XLEN  (32),
      .DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inPc     (inPc),
      .inPcN    (inPcN),
      .inInst   (inInst),
      .inReady  (inReady),
      .flush    (flush),
      .outValid (outValid),
      .outPc    (outPc),
      .outPcN   (outPcN),
      .outInst  (outInst),
      .outReady (outReady),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied for one edge, and the expected state right after that edge.
   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic [2:0]  cnt;
      logic        ir;
      logic        ov;
      logic [31:0] hpc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy, input logic [2:0] cnt, input logic ir,
                      input logic ov, input logic [31:0] hpc);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.cnt = cnt; v.ir = ir; v.ov = ov; v.hpc = hpc;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bundle fields derived from pc: pcN = pc+4, inst = pc+0x13.
   task automatic drive(input logic iv, input logic [31:0] pc);
      inValid = iv;
      inPc    = pc;
      inPcN   = pc + 32'h4;
      inInst  = pc + 32'h13;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; flush = 1'b0; outReady = 1'b0;
      drive(1'b0, 32'h0);

      //   rst  flush iv   pc         ordy  cnt  ir   ov   head pc
      // reset and pass-through (push into empty is not popped the same cycle)
      add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 3'd1, 1'b1, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      // fill to full, fifth bundle blocked, then drain in order
      add(1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h4,   1'b0, 3'd2, 1'b1, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h8,   1'b0, 3'd3, 1'b1, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'hC,   1'b0, 3'd4, 1'b0, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 3'd4, 1'b0, 1'b1, 32'h0);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd3, 1'b1, 1'b1, 32'h4);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd2, 1'b1, 1'b1, 32'h8);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b1, 1'b1, 32'hC);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      // simultaneous push/pop at count 2 for 10 cycles, pointers wrap
      add(1'b0, 1'b0, 1'b1, 32'h20,  1'b0, 3'd1, 1'b1, 1'b1, 32'h20);
      add(1'b0, 1'b0, 1'b1, 32'h24,  1'b0, 3'd2, 1'b1, 1'b1, 32'h20);
      for (int k = 0; k < 10; k++) begin
         add(1'b0, 1'b0, 1'b1, 32'h28 + 32'(4 * k), 1'b1, 3'd2, 1'b1, 1'b1,
             32'h24 + 32'(4 * k));
      end
      // full with pop: pop only, then the freed slot accepts the held bundle
      add(1'b0, 1'b0, 1'b1, 32'h50,  1'b0, 3'd3, 1'b1, 1'b1, 32'h48);
      add(1'b0, 1'b0, 1'b1, 32'h54,  1'b0, 3'd4, 1'b0, 1'b1, 32'h48);
      add(1'b0, 1'b0, 1'b1, 32'h58,  1'b1, 3'd3, 1'b1, 1'b1, 32'h4C);
      add(1'b0, 1'b0, 1'b1, 32'h58,  1'b0, 3'd4, 1'b0, 1'b1, 32'h4C);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd3, 1'b1, 1'b1, 32'h50);
      // flush overrides push and pop; redirected fetch lands next
      add(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 3'd1, 1'b1, 1'b1, 32'h200);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      // reset mid-stream drops in-flight entries and the concurrent push
      add(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 3'd1, 1'b1, 1'b1, 32'h300);
      add(1'b0, 1'b0, 1'b1, 32'h304, 1'b0, 3'd2, 1'b1, 1'b1, 32'h300);
      add(1'b1, 1'b0, 1'b1, 32'h308, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      add(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 3'd1, 1'b1, 1'b1, 32'h400);
      add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1, 1'b0, 32'h0);

      foreach (tbl[i]) begin
         rst      = tbl[i].rst;
         flush    = tbl[i].flush;
         outReady = tbl[i].ordy;
         drive(tbl[i].iv, tbl[i].pc);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d count", i),    32'(count),    32'(tbl[i].cnt));
         chk($sformatf("vec%0d inReady", i),  32'(inReady),  32'(tbl[i].ir));
         chk($sformatf("vec%0d outValid", i), 32'(outValid), 32'(tbl[i].ov));
         chk($sformatf("vec%0d outPc", i),    outPc,         tbl[i].hpc);
         chk($sformatf("vec%0d outPcN", i),   outPcN,
             tbl[i].ov ? tbl[i].hpc + 32'h4 : 32'h0);
         chk($sformatf("vec%0d outInst", i),  outInst,
             tbl[i].ov ? tbl[i].hpc + 32'h13 : 32'h0);
      end

      // Backpressure: fill, then check inReady has no combinational path from outReady
      rst = 1'b0; flush = 1'b0; outReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h500 + 32'(4 * k));
         @(posedge clk);
         #1;
      end
      drive(1'b0, 32'h0);
      chk("bp full count", 32'(count), 32'd4);
      chk("bp full inReady", 32'(inReady), 32'd0);
      outReady = 1'b1;
      #2;
      chk("bp inReady ignores outReady", 32'(inReady), 32'd0);
      chk("bp head before edge", outPc, 32'h500);
      outReady = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk("bp head stable pc", outPc, 32'h500);
         chk("bp head stable inst", outInst, 32'h513);
         chk("bp count stable", 32'(count), 32'd4);
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("bp flush count", 32'(count), 32'd0);
      chk("bp flush outValid", 32'(outValid), 32'd0);
      chk("bp flush inReady", 32'(inReady), 32'd1);
      chk("bp flush head zero", outPc, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and the ID stage. Each cycle it captures one fetched bundle {pcP, pcN, instOut} from IF and presents the oldest bundle to ID through a valid/ready handshake. Its not-full indication drives the IF stage's pcEn, so the program counter holds while the queue is full. A branch or redirect flush empties the queue in one cycle.

## Interface
Parameters:
- XLEN, 32, width of PC and instruction fields.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  IF presents a valid bundle this cycle.
- inPc  input  XLEN  fetched PC (pcP from IF).
- inPcN  input  XLEN  PC+4 (pcN from IF).
- inInst  input  XLEN  fetched instruction (instOut from IF).
- inReady  output  1  queue can accept a bundle; connects to IF pcEn.
- flush  input  1  discard all entries (branch taken / redirect).
- outValid  output  1  head entry is valid.
- outPc  output  XLEN  head entry PC.
- outPcN  output  XLEN  head entry PC+4.
- outInst  output  XLEN  head entry instruction.
- outReady  input  1  ID accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, pcN, inst}, plus a write pointer, a read pointer, and a count register. Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: occurs when inValid && inReady. The entry is written at wrPtr, then wrPtr increments.
- Pop: occurs when outValid && outReady. rdPtr increments.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
- inReady = (count != DEPTH). It is a registered-state function only and has no combinational path from outReady.
- outValid = (count != 0).
- Head outputs: outPc, outPcN and outInst show entry[rdPtr] while outValid = 1. They are forced to 0 while outValid = 0.
- No bypass: a bundle pushed into an empty queue cannot be popped in the same cycle.
- Full queue: push is blocked because inReady = 0, even if a pop happens that cycle. The freed slot is advertised in the next cycle.
- Flush: at the next edge, count, wrPtr and rdPtr all become 0.
  - Flush overrides any push or pop in the same cycle. The pushed bundle is discarded and the pop is void.
  - Entry storage contents are not cleared.
- Reset: same effect as flush and has priority over everything. After reset: count = 0, outValid = 0, inReady = 1, head outputs = 0.
- Reset or flush asserted mid-stream: all in-flight entries are lost. Nothing already in the queue may reach ID after that edge.
- Invariants:
  - count never exceeds DEPTH and never underflows.
  - rdPtr + count ≡ wrPtr (mod DEPTH).

## Timing
- Latency from push to head: 1 cycle. A bundle pushed at edge N is visible on the out* ports in cycle N+1 if the queue was empty.
- Throughput: 1 push and 1 pop per cycle sustained whenever 0 < count < DEPTH.
- inReady, outValid and count all change only at rising edges.
- The out* data ports change only at rising edges. This is not guaranteed to hold if entry storage is implemented with asynchronous reads: in that case they follow entry[rdPtr] combinationally, but they still change only when rdPtr, count or storage update.
- flush asserted in cycle N: outValid = 0 and inReady = 1 from cycle N+1. IF may push the redirected fetch in cycle N+1.
- The handshake must hold under backpressure:
  - While outValid = 1 and outReady = 0, the head outputs stay stable.
  - IF must keep its inputs stable while inValid = 1 and inReady = 0. The queue does not check this.

## Test plan
- Reset and basic pass-through: assert rst for 2 cycles, then check count = 0, outValid = 0, inReady = 1 and outInst = 0. Push {pc=0x0, pcN=0x4, inst=0x00000013} with outReady = 1 → the next cycle shows outValid = 1, outPc = 0x0, outPcN = 0x4, outInst = 0x13. The cycle after that shows outValid = 0.
- Fill to full: hold outReady = 0 and push 4 bundles with pc = 0x0, 0x4, 0x8, 0xC → count = 4 and inReady = 0. A 5th bundle held on inValid is not accepted: count stays 4. Then pop all four → outPc sequence 0x0, 0x4, 0x8, 0xC, then count = 0.
- Simultaneous push/pop: with count = 2, push and pop in the same cycle for 10 cycles → count stays 2, outPc advances by 4 every cycle, and the pointers wrap with no loss or duplication.
- Full with pop: at count = 4, assert outReady = 1 and inValid = 1 → that cycle pops 1 and pushes 0, giving count = 3. Next cycle inReady = 1 and the push succeeds.
- Flush priority: at count = 3, assert flush, inValid = 1 (pc = 0x100) and outReady = 1 in the same cycle → the next cycle has count = 0 and outValid = 0. Then push pc = 0x200 → the head shows outPc = 0x200, and 0x100 never appears.
- Reset mid-stream: at count = 2, assert rst together with inValid = 1 → count = 0, outValid = 0, inReady = 1. No stale entry is ever presented afterwards.
